// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if -- digit/flag inputs and the multiplexed LED outputs of
// the 8-digit seven-segment scan driver.
//   led1Number..led8Number : digit codes (led1 = rightmost, index 0)
//   point                  : decimal points, active-low, bit i = digit i
//   which_shine            : per-digit blink select
//   is_shine               : global blink enable
//   an                     : anodes, active-low one-hot
//   seg                    : segments {g,f,e,d,c,b,a}, active-low
//   dp                     : decimal point, active-low
// master = display-data producer, slave = scan driver.
interface seg_scan_driver_if;
   logic [3:0] led1Number;
   logic [3:0] led2Number;
   logic [3:0] led3Number;
   logic [3:0] led4Number;
   logic [3:0] led5Number;
   logic [3:0] led6Number;
   logic [3:0] led7Number;
   logic [3:0] led8Number;
   logic [7:0] point;
   logic [7:0] which_shine;
   logic       is_shine;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (
      output led1Number, led2Number, led3Number, led4Number,
             led5Number, led6Number, led7Number, led8Number,
             point, which_shine, is_shine,
      input  an, seg, dp
   );

   modport slave (
      input  led1Number, led2Number, led3Number, led4Number,
             led5Number, led6Number, led7Number, led8Number,
             point, which_shine, is_shine,
      output an, seg, dp
   );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver -- time-multiplexed 8-digit seven-segment driver with
// per-frame shadow registers, anode dead time and per-digit blinking.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : seg_scan_driver_if.slave (digit codes, points, blink controls in;
//           an/seg/dp out, all registered)
// Each digit owns a slot of SCAN_DIV cycles; the first DEAD cycles of a slot
// keep every anode off to avoid ghosting. Inputs are sampled into shadow
// registers only at the very end of a frame so one frame is never torn.
module seg_scan_driver #(
   parameter int SCAN_DIV  = 100000,
   parameter int DEAD      = 16,
   parameter int BLINK_DIV = 50000000
) (
   input  logic           clk,
   input  logic           reset,
   seg_scan_driver_if.slave bus
);

   localparam int CW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // scan position
   logic [CW-1:0]     cnt_q;
   logic [2:0]        idx_q;
   // blink phase
   logic [BW-1:0]     bcnt_q;
   logic              blink_on_q;
   // shadow copy of the inputs, held for a whole frame
   logic [7:0][3:0]   dig_q;
   logic [7:0]        point_q;
   logic [7:0]        shine_q;
   logic              is_shine_q;
   // registered outputs
   logic [7:0]        an_q,  an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q,  dp_d;

   logic [7:0][3:0]   dig_in;
   logic              slot_end;
   logic              frame_end;
   logic              bwrap;
   logic              hide;

   assign dig_in = {bus.led8Number, bus.led7Number, bus.led6Number, bus.led5Number,
                    bus.led4Number, bus.led3Number, bus.led2Number, bus.led1Number};

   function automatic logic [6:0] decode(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h3F;      // dash: only segment g lit
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   always_comb begin
      slot_end  = (cnt_q == CW'(SCAN_DIV - 1));
      frame_end = slot_end && (idx_q == 3'd7);
      bwrap     = (bcnt_q == BW'(BLINK_DIV - 1));
      // blanked half of the blink period for a selected digit
      hide      = is_shine_q && shine_q[idx_q] && !blink_on_q;

      an_d  = 8'hFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (cnt_q >= CW'(DEAD)) begin
         an_d = ~(8'h01 << idx_q);
         if (!hide) begin
            seg_d = decode(dig_q[idx_q]);
            dp_d  = point_q[idx_q];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         bcnt_q     <= '0;
         blink_on_q <= 1'b1;
         dig_q      <= {8{4'hF}};
         point_q    <= 8'hFF;
         shine_q    <= 8'h00;
         is_shine_q <= 1'b0;
         an_q       <= 8'hFF;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;

         if (slot_end) begin
            cnt_q <= '0;
            idx_q <= idx_q + 3'd1;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end

         if (frame_end) begin
            dig_q      <= dig_in;
            point_q    <= bus.point;
            shine_q    <= bus.which_shine;
            is_shine_q <= bus.is_shine;
         end

         // blink phase restarts visible whenever blinking is off
         if (is_shine_q) begin
            if (bwrap) begin
               bcnt_q     <= '0;
               blink_on_q <= !blink_on_q;
            end else begin
               bcnt_q <= bcnt_q + BW'(1);
            end
         end else begin
            bcnt_q     <= '0;
            blink_on_q <= 1'b1;
         end
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver -- directed bench for seg_scan_driver with
// SCAN_DIV=4, DEAD=1, BLINK_DIV=8 (4 cycles per slot, 32 per frame).
// Frames after reset release:
//   1: blank (shadow still reset), inputs = "12-43-50"
//   2: "12-43-50", point=FF; point changed to EB during this frame
//   3: same digits, dp low on idx2/idx4; all inputs changed while idx=3
//   4: new digits with blinking on idx0..3 (idx2/3 fall in the off phase)
//   5: blinking dropped, all digits visible
module tb_seg_scan_driver;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   logic [6:0] exp_seg [8];
   logic       exp_dp  [8];

   seg_scan_driver_if u_if ();

   seg_scan_driver #(
      .SCAN_DIV  (4),
      .DEAD      (1),
      .BLINK_DIV (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_out(input string tag, input logic [7:0] an_e,
                          input logic [6:0] seg_e, input logic dp_e);
      chk({tag, ".an"},  u_if.an,          an_e);
      chk({tag, ".seg"}, {1'b0, u_if.seg}, {1'b0, seg_e});
      chk({tag, ".dp"},  {7'd0, u_if.dp},  {7'd0, dp_e});
   endtask

   // one digit slot: a dead cycle then three lit cycles
   task automatic run_slot(input int f, input int i);
      logic [7:0] an_e;
      an_e = ~(8'h01 << i);
      for (int c = 0; c < 4; c++) begin
         tick();
         if (c == 0)
            chk_out($sformatf("f%0d_i%0d_dead", f, i), 8'hFF, 7'h7F, 1'b1);
         else
            chk_out($sformatf("f%0d_i%0d_c%0d", f, i, c), an_e, exp_seg[i], exp_dp[i]);
      end
   endtask

   task automatic set_digits(input logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7);
      u_if.led1Number = d0; u_if.led2Number = d1;
      u_if.led3Number = d2; u_if.led4Number = d3;
      u_if.led5Number = d4; u_if.led6Number = d5;
      u_if.led7Number = d6; u_if.led8Number = d7;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      set_digits(4'h1, 4'h2, 4'hA, 4'h4, 4'h3, 4'hA, 4'h5, 4'h0);
      u_if.point       = 8'hFF;
      u_if.which_shine = 8'h00;
      u_if.is_shine    = 1'b0;
      #1 reset = 1'b1;
      #10;
      chk_out("reset_initial", 8'hFF, 7'h7F, 1'b1);
      @(negedge clk) reset = 1'b0;

      // run into slot idx1, then reset asynchronously mid-slot
      repeat (6) tick();
      chk({"pre_reset.an"}, u_if.an, 8'hFD);
      #2 reset = 1'b1;
      #1;
      chk_out("reset_midslot", 8'hFF, 7'h7F, 1'b1);
      @(negedge clk) reset = 1'b0;

      // frame 1: shadow still holds reset values -> blank digits
      for (int i = 0; i < 8; i++) begin
         exp_seg[i] = 7'h7F;
         exp_dp[i]  = 1'b1;
      end
      for (int i = 0; i < 8; i++) run_slot(1, i);

      // frame 2: "12-43-50"; point changed now only takes effect in frame 3
      u_if.point = 8'hEB;
      exp_seg[0] = 7'h79; exp_seg[1] = 7'h24; exp_seg[2] = 7'h3F; exp_seg[3] = 7'h19;
      exp_seg[4] = 7'h30; exp_seg[5] = 7'h3F; exp_seg[6] = 7'h12; exp_seg[7] = 7'h40;
      for (int i = 0; i < 8; i++) run_slot(2, i);

      // frame 3: points on idx2/idx4; inputs changed while idx=3 must not show
      exp_dp[2] = 1'b0;
      exp_dp[4] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         run_slot(3, i);
         if (i == 2) begin
            set_digits(4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'hB, 4'h3, 4'h2);
            u_if.point       = 8'hFF;
            u_if.which_shine = 8'h0F;
            u_if.is_shine    = 1'b1;
         end
      end

      // frame 4: blink phase visible for idx0/1 slots, blank for idx2/3 slots
      u_if.is_shine = 1'b0;
      exp_seg[0] = 7'h10; exp_seg[1] = 7'h00; exp_seg[2] = 7'h7F; exp_seg[3] = 7'h7F;
      exp_seg[4] = 7'h12; exp_seg[5] = 7'h7F; exp_seg[6] = 7'h30; exp_seg[7] = 7'h24;
      for (int i = 0; i < 8; i++) exp_dp[i] = 1'b1;
      for (int i = 0; i < 8; i++) run_slot(4, i);

      // frame 5: blinking dropped -> idx2/3 visible again
      exp_seg[2] = 7'h78;
      exp_seg[3] = 7'h02;
      for (int i = 0; i < 8; i++) run_slot(5, i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // watchdog so the run always ends
   initial begin
      #20000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
